// File: rtl/csr_timer_pkg.sv
// Shared constants and helpers for the CSR constant-timer unit: address map,
// TCFG field positions and the masked CSR write merge.
package csr_timer_pkg;

    localparam int CSR_TIMER_BASE   = 'h40;
    localparam int CSR_TIMER_STRIDE = 8;

    localparam int OFF_TCFG  = 1;
    localparam int OFF_TVAL  = 2;
    localparam int OFF_TICLR = 4;

    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;

    // CSR address of register 'off' within timer channel 'chan'
    function automatic logic [13:0] timer_csr_addr(input int chan, input int off);
        return 14'(CSR_TIMER_BASE + CSR_TIMER_STRIDE * chan + off);
    endfunction

    // Masked write: bits with wmask set take wvalue, others keep the old value
    function automatic logic [31:0] csr_merge(input logic [31:0] old,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wvalue);
        return (wmask & wvalue) | (~wmask & old);
    endfunction

endpackage

// File: rtl/csr_timer_unit_channel.sv
// One countdown timer channel: owns its TCFG register, the counter and the
// pending flag. Counting advances only on the shared prescaler tick.
module timer_channel
    import csr_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tcfg_we,
    input  logic             ticlr_we,
    input  logic             tick,
    input  logic [31:0]      wmask,
    input  logic [31:0]      wvalue,
    output logic [CNT_W-1:0] tcfg,
    output logic [CNT_W-1:0] tval,
    output logic             pending
);

    logic [31:0]      merged;
    logic [CNT_W-1:0] tcfg_new;
    logic [CNT_W-1:0] load_new;
    logic [CNT_W-1:0] load_cur;
    logic [CNT_W-1:0] cnt;
    logic             en;
    logic             periodic;
    logic             counting;
    logic             expiry;
    logic             clear;

    assign merged   = csr_merge(32'(tcfg), wmask, wvalue);
    assign tcfg_new = merged[CNT_W-1:0];
    // Load value is initval with the two control bit positions forced to zero
    assign load_new = {tcfg_new[CNT_W-1:TCFG_INITVAL_LSB], 2'b00};
    assign load_cur = {tcfg[CNT_W-1:TCFG_INITVAL_LSB], 2'b00};

    assign en       = tcfg[TCFG_EN];
    assign periodic = tcfg[TCFG_PERIODIC];
    // All-ones is the parked state of an expired one-shot timer
    assign counting = en & tick & (cnt != '1);
    assign expiry   = en & tick & (cnt == '0);
    assign clear    = ticlr_we & wmask[0] & wvalue[0];

    assign tval = cnt;

    // TCFG register: masked CSR write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg <= '0;
        end else if (tcfg_we) begin
            tcfg <= tcfg_new;
        end
    end

    // Counter: a TCFG write (load or freeze) wins over a tick in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '1;
        end else if (tcfg_we) begin
            if (tcfg_new[TCFG_EN]) begin
                cnt <= load_new;
            end
        end else if (counting) begin
            if ((cnt == '0) && periodic) begin
                cnt <= load_cur;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Pending flag: expiry sets it, TICLR clears it, set wins on collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else if (expiry) begin
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/csr_timer_unit.sv
// Multi-channel constant-timer unit behind the masked CSR write port:
// address decode, shared tick prescaler, 64-bit stable counter, read mux.
module csr_timer_unit
    import csr_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 2,
    parameter int CNT_W      = 32,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  csr_we,
    input  logic [13:0]           csr_num,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic [31:0]           csr_rvalue,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic [63:0]           stable_cnt
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]       prescaler;
    logic                  tick;
    logic [NUM_TIMERS-1:0] tcfg_we;
    logic [NUM_TIMERS-1:0] ticlr_we;
    logic [NUM_TIMERS-1:0] pending;
    logic [CNT_W-1:0]      tcfg [NUM_TIMERS];
    logic [CNT_W-1:0]      tval [NUM_TIMERS];

    // With PRESCALE = 1 the prescaler sits at 0 and every cycle is a tick
    assign tick = (prescaler == PS_W'(PRESCALE - 1));

    // Prescaler: free-running 0..PRESCALE-1, untouched by TCFG writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // Stable counter: unprescaled, wraps at 2^64
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 64'd1;
        end
    end

    // Write decode: one TCFG and one TICLR strobe per channel
    always_comb begin
        tcfg_we  = '0;
        ticlr_we = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tcfg_we[i]  = csr_we && (csr_num == timer_csr_addr(i, OFF_TCFG));
            ticlr_we[i] = csr_we && (csr_num == timer_csr_addr(i, OFF_TICLR));
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .resetn   (resetn),
            .tcfg_we  (tcfg_we[g]),
            .ticlr_we (ticlr_we[g]),
            .tick     (tick),
            .wmask    (csr_wmask),
            .wvalue   (csr_wvalue),
            .tcfg     (tcfg[g]),
            .tval     (tval[g]),
            .pending  (pending[g])
        );
    end

    assign timer_int = pending;

    // Read mux: TCFG/TVAL zero-extended; TICLR, TID and unmapped read 0
    always_comb begin
        csr_rvalue = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (csr_num == timer_csr_addr(i, OFF_TCFG)) begin
                csr_rvalue = 32'(tcfg[i]);
            end else if (csr_num == timer_csr_addr(i, OFF_TVAL)) begin
                csr_rvalue = 32'(tval[i]);
            end
        end
    end

endmodule

// File: tb/tb_csr_timer_unit.sv
// Bench for csr_timer_unit: directed CSR sequences on a PRESCALE=1 unit with a
// tick-counting reference model checked every cycle, plus a PRESCALE=4,
// 16-bit, single-channel unit checked with hand-computed values.
module tb_csr_timer_unit;

    localparam int NT = 2;
    localparam int CW = 32;
    localparam int PS = 1;
    localparam longint ONES = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          csr_we;
    logic [13:0]   csr_num;
    logic [31:0]   csr_wmask;
    logic [31:0]   csr_wvalue;
    logic [31:0]   csr_rvalue;
    logic [NT-1:0] timer_int;
    logic [63:0]   stable_cnt;

    logic          resetn_b;
    logic          b_we;
    logic [13:0]   b_num;
    logic [31:0]   b_wmask;
    logic [31:0]   b_wvalue;
    logic [31:0]   b_rvalue;
    logic [0:0]    b_int;
    logic [63:0]   b_stable;

    csr_timer_unit #(.NUM_TIMERS(NT), .CNT_W(CW), .PRESCALE(PS)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_we     (csr_we),
        .csr_num    (csr_num),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_rvalue (csr_rvalue),
        .timer_int  (timer_int),
        .stable_cnt (stable_cnt)
    );

    csr_timer_unit #(.NUM_TIMERS(1), .CNT_W(16), .PRESCALE(4)) dut_b (
        .clk        (clk),
        .resetn     (resetn_b),
        .csr_we     (b_we),
        .csr_num    (b_num),
        .csr_wmask  (b_wmask),
        .csr_wvalue (b_wvalue),
        .csr_rvalue (b_rvalue),
        .timer_int  (b_int),
        .stable_cnt (b_stable)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: each channel is described by its TCFG, the counter value
    // at its last load/freeze (base) and the ticks seen since then.
    logic [31:0]   m_tcfg [NT];
    longint        m_base [NT];
    longint        m_n    [NT];
    logic [NT-1:0] m_pend;
    int            m_ps;
    logic [63:0]   m_stable;

    function automatic longint m_cnt(input int i);
        longint b, n, l;
        b = m_base[i];
        n = m_n[i];
        if (n <= b) return b - n;
        if (!m_tcfg[i][1]) return ONES;
        l = longint'(m_tcfg[i] & 32'hFFFF_FFFC);
        return l - ((n - b - 1) % (l + 1));
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        for (int i = 0; i < NT; i++) begin
            if (a == 14'(64 + 8 * i + 1)) return m_tcfg[i];
            if (a == 14'(64 + 8 * i + 2)) return 32'(m_cnt(i));
        end
        return 32'd0;
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        bit          tk;
        longint      cur;
        logic        en;
        logic [31:0] nw;
        if (!resetn) begin
            for (int i = 0; i < NT; i++) begin
                m_tcfg[i] = '0;
                m_base[i] = ONES;
                m_n[i]    = 0;
            end
            m_pend   = '0;
            m_ps     = 0;
            m_stable = '0;
        end else begin
            tk = (m_ps == PS - 1);
            for (int i = 0; i < NT; i++) begin
                cur = m_cnt(i);
                en  = m_tcfg[i][0];
                if (en && tk && cur == 0)
                    m_pend[i] = 1'b1;
                else if (csr_we && csr_num == 14'(64 + 8 * i + 4) && csr_wmask[0] && csr_wvalue[0])
                    m_pend[i] = 1'b0;
                if (csr_we && csr_num == 14'(64 + 8 * i + 1)) begin
                    nw = ((csr_wmask & csr_wvalue) | (~csr_wmask & m_tcfg[i])) & 32'(ONES);
                    m_tcfg[i] = nw;
                    m_n[i]    = 0;
                    m_base[i] = nw[0] ? longint'(nw & 32'hFFFF_FFFC) : cur;
                end else if (en && tk) begin
                    m_n[i] = m_n[i] + 1;
                end
            end
            m_ps     = (m_ps + 1) % PS;
            m_stable = m_stable + 64'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (resetn && check_en) begin
            chk("timer_int", 64'(timer_int), 64'(m_pend));
            chk("stable_cnt", stable_cnt, m_stable);
            chk("csr_rvalue", 64'(csr_rvalue), 64'(m_read(csr_num)));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_we     = 1'b1;
        csr_num    = a;
        csr_wmask  = m;
        csr_wvalue = v;
        step();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
        csr_num = a;
        #1;
        chk(name, 64'(csr_rvalue), 64'(exp));
    endtask

    task automatic b_wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        b_we     = 1'b1;
        b_num    = a;
        b_wmask  = m;
        b_wvalue = v;
        step();
        b_we = 1'b0;
    endtask

    task automatic b_rd_chk(input string name, input logic [13:0] a, input logic [31:0] exp);
        b_num = a;
        #1;
        chk(name, 64'(b_rvalue), 64'(exp));
    endtask

    initial begin
        int c;
        resetn = 1'b1; resetn_b = 1'b1;
        csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
        b_we = 1'b0; b_num = '0; b_wmask = '0; b_wvalue = '0;
        #2;
        resetn = 1'b0; resetn_b = 1'b0;
        step(3);
        resetn = 1'b1; resetn_b = 1'b1;
        check_en = 1'b1;

        // Reset state
        rd_chk("rst_tval0", 14'h042, 32'hFFFF_FFFF);
        rd_chk("rst_tcfg0", 14'h041, 32'h0);
        chk("rst_timer_int", 64'(timer_int), 64'd0);
        b_rd_chk("b_rst_tval0", 14'h042, 32'h0000_FFFF);
        step(5);
        chk("rst_stable_5", stable_cnt, 64'd5);

        // One-shot, L = 20
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0015);
        step(20);
        chk("oneshot_int_k20", 64'(timer_int[0]), 64'd0);
        rd_chk("oneshot_tval_k20", 14'h042, 32'h0);
        step(1);
        chk("oneshot_int_k21", 64'(timer_int[0]), 64'd1);
        rd_chk("oneshot_tval_k21", 14'h042, 32'hFFFF_FFFF);
        wr(14'h044, 32'h1, 32'h1);
        chk("oneshot_clr", 64'(timer_int[0]), 64'd0);
        step(100);
        chk("oneshot_no_rearm", 64'(timer_int[0]), 64'd0);

        // Periodic, L = 8, with clears
        wr(14'h049, 32'hFFFF_FFFF, 32'h0000_000B);
        step(8);
        chk("per_int_k8", 64'(timer_int[1]), 64'd0);
        rd_chk("per_tval_k8", 14'h04A, 32'h0);
        step(1);
        chk("per_int_k9", 64'(timer_int[1]), 64'd1);
        rd_chk("per_tval_k9", 14'h04A, 32'h8);
        wr(14'h04C, 32'h1, 32'h1);
        chk("per_clr_k10", 64'(timer_int[1]), 64'd0);
        step(7);
        chk("per_low_k17", 64'(timer_int[1]), 64'd0);
        step(1);
        chk("per_high_k18", 64'(timer_int[1]), 64'd1);
        wr(14'h04C, 32'h1, 32'h1);
        chk("per_clr_k19", 64'(timer_int[1]), 64'd0);
        step(7);
        chk("per_low_k26", 64'(timer_int[1]), 64'd0);
        wr(14'h04C, 32'h1, 32'h1);
        chk("per_set_wins_k27", 64'(timer_int[1]), 64'd1);
        wr(14'h04C, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        chk("per_masked_clr_ignored", 64'(timer_int[1]), 64'd1);
        wr(14'h049, 32'h1, 32'h0);
        step(20);
        rd_chk("per_frozen_tcfg1", 14'h049, 32'h0000_000A);

        // Masked write reloads the counter
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0101);
        rd_chk("mask_tcfg0_a", 14'h041, 32'h0000_0101);
        rd_chk("mask_tval0_a", 14'h042, 32'h0000_0100);
        step(1);
        rd_chk("mask_tval0_dec", 14'h042, 32'h0000_00FF);
        wr(14'h041, 32'h0000_0002, 32'hFFFF_FFFE);
        rd_chk("mask_tcfg0_b", 14'h041, 32'h0000_0103);
        rd_chk("mask_tval0_b", 14'h042, 32'h0000_0100);

        // Decode: unmapped, TID and TICLR addresses
        wr(14'h043, 32'hFFFF_FFFF, 32'h0000_0015);
        rd_chk("dec_0x43", 14'h043, 32'h0);
        rd_chk("dec_0x51", 14'h051, 32'h0);
        step(1);
        rd_chk("dec_0x44", 14'h044, 32'h0);
        rd_chk("dec_0x40", 14'h040, 32'h0);
        rd_chk("dec_tcfg0_kept", 14'h041, 32'h0000_0103);

        // L = 0 periodic: expiry every tick, so a clear cannot drop the line
        wr(14'h049, 32'hFFFF_FFFF, 32'h0000_0003);
        step(2);
        chk("l0_int", 64'(timer_int[1]), 64'd1);
        wr(14'h04C, 32'h1, 32'h1);
        chk("l0_clr_stays_high", 64'(timer_int[1]), 64'd1);
        step(5);

        // PRESCALE = 4, CNT_W = 16: upper TCFG bits dropped, L = 4 -> 5 ticks
        b_wr(14'h041, 32'hFFFF_FFFF, 32'hFFFF_0005);
        b_rd_chk("b_tcfg_trunc", 14'h041, 32'h0000_0005);
        c = 0;
        while (!b_int[0] && c < 40) begin
            step(1);
            c++;
        end
        n_chk++;
        if (!(c >= 17 && c <= 23)) begin
            n_fail++;
            $display("FAIL b_prescale_rise: actual %0d cycles required 17..23", c);
        end
        step(3);
        chk("b_int_held", 64'(b_int), 64'd1);
        resetn_b = 1'b0;
        #1;
        chk("b_async_rst_int", 64'(b_int), 64'd0);
        chk("b_async_rst_stable", b_stable, 64'd0);
        b_rd_chk("b_async_rst_tval", 14'h042, 32'h0000_FFFF);
        resetn_b = 1'b1;
        step(1);
        chk("b_stable_after_release", b_stable, 64'd1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
